// File: rtl/nlfsr_tap_engine_if.sv
// Handshake and data bundle between the host/config side and the NLFSR tap engine.
`timescale 1ns/1ps
interface nlfsr_tap_engine_if #(
   parameter int SIZE = 32
);
   logic            start;
   logic [7:0]      cfg_data;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [SIZE-1:0] seed;
   logic            seed_valid;
   logic            step;
   logic            out_bit;
   logic            out_valid;
   logic [SIZE-1:0] register_q;
   logic            running;
   logic            cfg_err;
   logic            zero_lock;

   modport master (
      output start, cfg_data, cfg_valid, seed, seed_valid, step,
      input  cfg_ready, out_bit, out_valid, register_q, running, cfg_err, zero_lock
   );

   modport slave (
      input  start, cfg_data, cfg_valid, seed, seed_valid, step,
      output cfg_ready, out_bit, out_valid, register_q, running, cfg_err, zero_lock
   );
endinterface

// File: rtl/nlfsr_tap_engine.sv
// NLFSR keystream generator: byte-serial tap loading, seeding, then one output bit per step
// with feedback from AND-triples and linear XOR taps.
`timescale 1ns/1ps
module nlfsr_tap_engine #(
   parameter int SIZE        = 32,
   parameter int NUM_TRIPLES = 2,
   parameter int NUM_LIN     = 2
) (
   input logic                clk,
   input logic                res,
   nlfsr_tap_engine_if.slave  bus
);
   localparam int NUM_OF_TAPS = 3*NUM_TRIPLES + NUM_LIN;
   localparam int IDX_W       = $clog2(SIZE);
   localparam int CNT_W       = $clog2(NUM_OF_TAPS + 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      SEED = 3'd2,
      RUN  = 3'd3,
      ERR  = 3'd4
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] tap_r [NUM_OF_TAPS];
   logic [CNT_W-1:0] cnt_r;
   logic [SIZE-1:0]  reg_r;
   logic             out_bit_r;
   logic             out_valid_r;
   logic             cfg_err_r;
   logic             fb_s;
   logic             accept_s;

   // Index 0 is reserved and nothing at or beyond SIZE addresses a register bit.
   function automatic logic idx_legal(input logic [7:0] b);
      return (b != 8'd0) && ({1'b0, b} < 9'(SIZE));
   endfunction

   assign accept_s = bus.cfg_valid && (state_r == LOAD);

   // Feedback: XOR of every AND-triple product with every linear tap.
   always_comb begin
      fb_s = 1'b0;
      for (int t = 0; t < NUM_TRIPLES; t++) begin
         fb_s = fb_s ^ (reg_r[tap_r[3*t]] & reg_r[tap_r[3*t+1]] & reg_r[tap_r[3*t+2]]);
      end
      for (int l = 0; l < NUM_LIN; l++) begin
         fb_s = fb_s ^ reg_r[tap_r[3*NUM_TRIPLES+l]];
      end
   end

   // Control FSM, tap storage and shift register; start overrides every other input.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         reg_r       <= {SIZE{1'b0}};
         out_bit_r   <= 1'b0;
         out_valid_r <= 1'b0;
         cfg_err_r   <= 1'b0;
         for (int k = 0; k < NUM_OF_TAPS; k++) begin
            tap_r[k] <= {IDX_W{1'b0}};
         end
      end else if (bus.start) begin
         state_r     <= LOAD;
         cnt_r       <= CNT_W'(1);
         cfg_err_r   <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
            end
            LOAD: begin
               if (accept_s) begin
                  if (idx_legal(bus.cfg_data)) begin
                     for (int k = 0; k < NUM_OF_TAPS; k++) begin
                        if (cnt_r == CNT_W'(k + 1)) begin
                           tap_r[k] <= bus.cfg_data[IDX_W-1:0];
                        end
                     end
                     cnt_r <= cnt_r + CNT_W'(1);
                     if (cnt_r == CNT_W'(NUM_OF_TAPS)) begin
                        state_r <= SEED;
                     end
                  end else begin
                     cfg_err_r <= 1'b1;
                     state_r   <= ERR;
                  end
               end
            end
            SEED: begin
               if (bus.seed_valid) begin
                  reg_r   <= bus.seed;
                  state_r <= RUN;
               end
            end
            RUN: begin
               if (bus.step) begin
                  reg_r       <= {reg_r[0] ^ fb_s, reg_r[SIZE-1:1]};
                  out_bit_r   <= reg_r[0];
                  out_valid_r <= 1'b1;
               end
            end
            ERR: begin
               state_r <= ERR;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_ready  = (state_r == LOAD);
   assign bus.running    = (state_r == RUN);
   assign bus.zero_lock  = (state_r == RUN) && (reg_r == {SIZE{1'b0}});
   assign bus.register_q = reg_r;
   assign bus.out_bit    = out_bit_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.cfg_err    = cfg_err_r;
endmodule

// File: tb/tb_nlfsr_tap_engine.sv
// Self-checking bench for nlfsr_tap_engine: table-driven tap loads, random stepping against a
// queue-based reference model, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_nlfsr_tap_engine;
   localparam int SIZE = 32;

   logic clk = 1'b0;
   logic res = 1'b0;

   nlfsr_tap_engine_if #(.SIZE(SIZE)) bus ();
   nlfsr_tap_engine #(.SIZE(SIZE), .NUM_TRIPLES(2), .NUM_LIN(2)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: mq[i] holds register bit i; stepping pops bit 0 and appends the new MSB.
   int mq[$];
   int mtaps[8];

   typedef struct {
      logic [63:0] idx;     // byte k at bits 8k+7:8k, first byte in the LSBs
      int          err_at;  // 1-based position of the illegal byte, 0 if all legal
   } vec_t;
   vec_t tab[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic void model_load(input logic [31:0] s);
      mq.delete();
      for (int i = 0; i < SIZE; i++) mq.push_back(int'(s[i]));
   endfunction

   function automatic logic [31:0] mvec();
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < SIZE; i++) v[i] = mq[i][0];
      return v;
   endfunction

   function automatic int model_step();
      int sum;
      int o;
      sum = 0;
      for (int t = 0; t < 2; t++) sum += mq[mtaps[3*t]] * mq[mtaps[3*t+1]] * mq[mtaps[3*t+2]];
      for (int l = 0; l < 2; l++) sum += mq[mtaps[6+l]];
      o = mq.pop_front();
      mq.push_back((o + sum) % 2);
      return o;
   endfunction

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_cfg_err", bus.cfg_err, 0);
      chk("start_cfg_ready", bus.cfg_ready, 1);
      chk("start_out_valid", bus.out_valid, 0);
      chk("start_reg_held", bus.register_q, mvec());
   endtask

   task automatic load_all(input logic [63:0] idx);
      for (int k = 0; k < 8; k++) begin
         bus.cfg_data  = idx[8*k +: 8];
         bus.cfg_valid = 1'b1;
         mtaps[k]      = int'(idx[8*k +: 8]);
         tick();
      end
      bus.cfg_valid = 1'b0;
   endtask

   task automatic seed_with(input logic [31:0] s);
      bus.seed       = s;
      bus.seed_valid = 1'b1;
      tick();
      bus.seed_valid = 1'b0;
      model_load(s);
   endtask

   task automatic step_check(input string tag, input logic s);
      int ob;
      bus.step = s;
      tick();
      bus.step = 1'b0;
      chk({tag, "_valid"}, bus.out_valid, s);
      if (s) begin
         ob = model_step();
         chk({tag, "_bit"}, bus.out_bit, ob[0]);
      end
      chk({tag, "_reg"}, bus.register_q, mvec());
   endtask

   initial begin
      int acc;
      bus.start = 1'b0; bus.cfg_data = 8'd0; bus.cfg_valid = 1'b0;
      bus.seed = 32'd0; bus.seed_valid = 1'b0; bus.step = 1'b0;
      model_load(32'd0);

      tab[0] = '{idx: 64'h0101_0101_0101_0101, err_at: 0};
      tab[1] = '{idx: 64'h0A0B_0C0D_0E20_0703, err_at: 3};
      tab[2] = '{idx: 64'h0505_0505_0505_0500, err_at: 1};
      tab[3] = '{idx: 64'h1304_0802_111E_011F, err_at: 0};
      tab[4] = '{idx: 64'hFF07_0605_0403_0201, err_at: 8};
      tab[5] = '{idx: 64'h0916_0E07_1F03_190C, err_at: 0};

      // Reset state
      tick();
      chk("rst_reg", bus.register_q, 32'd0);
      chk("rst_out_bit", bus.out_bit, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_cfg_ready", bus.cfg_ready, 0);
      chk("rst_running", bus.running, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      chk("rst_zero_lock", bus.zero_lock, 0);
      res = 1'b1;
      tick();

      // Table-driven loads; legal ones are then seeded randomly and stepped randomly.
      for (int r = 0; r < 6; r++) begin
         do_start();
         for (int k = 0; k < 8; k++) begin
            if (tab[r].err_at == 0 || k < tab[r].err_at) begin
               bus.cfg_data  = tab[r].idx[8*k +: 8];
               bus.cfg_valid = 1'b1;
               mtaps[k]      = int'(tab[r].idx[8*k +: 8]);
               tick();
            end
         end
         bus.cfg_valid = 1'b0;
         if (tab[r].err_at != 0) begin
            chk("err_cfg_err", bus.cfg_err, 1);
            chk("err_cfg_ready", bus.cfg_ready, 0);
            chk("err_running", bus.running, 0);
            bus.step = 1'b1; bus.cfg_valid = 1'b1; bus.seed_valid = 1'b1;
            tick(); tick();
            bus.step = 1'b0; bus.cfg_valid = 1'b0; bus.seed_valid = 1'b0;
            chk("err_step_ignored", bus.out_valid, 0);
            chk("err_reg_held", bus.register_q, mvec());
            chk("err_sticky", bus.cfg_err, 1);
         end else begin
            chk("seed_cfg_ready", bus.cfg_ready, 0);
            chk("seed_running", bus.running, 0);
            chk("seed_cfg_err", bus.cfg_err, 0);
            step_check("seed_step_ignored", 1'b0);
            bus.step = 1'b1; tick(); bus.step = 1'b0;
            chk("seed_step_no_valid", bus.out_valid, 0);
            seed_with($urandom | 32'd1);
            chk("run_running", bus.running, 1);
            chk("run_seed_loaded", bus.register_q, mvec());
            for (int c = 0; c < 40; c++) step_check("rand_step", 1'($urandom_range(0, 1)));
         end
      end

      // Rotation: all taps index 1 cancel, so the register simply rotates.
      do_start();
      load_all(64'h0101_0101_0101_0101);
      seed_with(32'h0000_0001);
      for (int c = 0; c < 32; c++) begin
         bus.step = 1'b1; tick(); bus.step = 1'b0;
         chk("rot_valid", bus.out_valid, 1);
         chk("rot_bit", bus.out_bit, (c == 0) ? 1 : 0);
         if (c == 0) chk("rot_first_reg", bus.register_q, 32'h8000_0000);
      end
      chk("rot_final_reg", bus.register_q, 32'h0000_0001);
      model_load(32'h0000_0001);

      // Zero seed locks up: outputs zeros, register stays zero.
      do_start();
      load_all(64'h0B04_111E_020D_0905);
      chk("zs_pre_lock", bus.zero_lock, 0);
      seed_with(32'd0);
      chk("zs_zero_lock", bus.zero_lock, 1);
      for (int c = 0; c < 5; c++) begin
         bus.step = 1'b1; tick(); bus.step = 1'b0;
         chk("zs_valid", bus.out_valid, 1);
         chk("zs_bit", bus.out_bit, 0);
         chk("zs_reg", bus.register_q, 32'd0);
      end
      chk("zs_lock_held", bus.zero_lock, 1);

      // Handshake stall: cfg_valid alternates, 8 acceptances, SEED right after the 8th.
      do_start();
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         bus.cfg_valid = (i % 2 == 0);
         bus.cfg_data  = 8'(i + 1);
         if (i == 14) chk("stall_ready_before_last", bus.cfg_ready, 1);
         if (bus.cfg_valid && bus.cfg_ready) acc++;
         tick();
         if (i == 14) chk("stall_seed_after_8th", bus.cfg_ready, 0);
      end
      bus.cfg_valid = 1'b0;
      chk("stall_accept_count", acc, 8);
      chk("stall_no_err", bus.cfg_err, 0);
      seed_with(32'hDEAD_BEEF);
      chk("stall_running", bus.running, 1);

      // Asynchronous reset in the middle of LOAD.
      do_start();
      for (int k = 0; k < 4; k++) begin
         bus.cfg_data = 8'(k + 2); bus.cfg_valid = 1'b1; tick();
      end
      bus.cfg_valid = 1'b0;
      res = 1'b0;
      #1;
      chk("mrst_reg", bus.register_q, 32'd0);
      chk("mrst_out_bit", bus.out_bit, 0);
      chk("mrst_cfg_ready", bus.cfg_ready, 0);
      chk("mrst_running", bus.running, 0);
      chk("mrst_cfg_err", bus.cfg_err, 0);
      tick();
      res = 1'b1;
      model_load(32'd0);
      bus.cfg_data = 8'h05; bus.cfg_valid = 1'b1;
      tick(); tick();
      bus.cfg_valid = 1'b0;
      chk("mrst_valid_ignored", bus.cfg_ready, 0);
      chk("mrst_still_idle_err", bus.cfg_err, 0);
      chk("mrst_still_idle_run", bus.running, 0);
      do_start();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
